// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, NOP encoding
// and IF state encoding. Decode imports the same constants.
package if_stage_pkg;

    localparam int IF_PC_W    = 32;
    localparam int IF_INSTR_W = 32;

    // Opcode 2'b00 with all-zero fields is a no-op in decode.
    localparam logic [IF_INSTR_W-1:0] IF_NOP = '0;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry {instr, pc} holding register that catches the word fetched while
// decode is stalled. Clear wins over load.
module if_skid_buf #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic [INSTR_W-1:0] held_instr,
    output logic [PC_W-1:0]    held_pc,
    output logic               full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end
    end

    // Payload is only meaningful while full is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            held_instr <= load_instr;
            held_pc    <= load_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, req/ack imem port, IF/ID register,
// decode stall with one-entry skid, EX redirect. Optional IF_PERF_CNT_EN adds
// fetch/bubble counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int              PC_W     = IF_PC_W,
    parameter int              INSTR_W  = IF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        bubble_cnt_o
`endif
);

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc_cur);
        return pc_cur + PC_W'(PC_STEP);
    endfunction

    if_state_t           state, state_next;
    logic [PC_W-1:0]     pc;
    logic                accept;
    logic                to_ifid;
    logic                to_skid;
    logic                unload;
    logic [INSTR_W-1:0]  skid_instr;
    logic [PC_W-1:0]     skid_pc;
    logic                skid_full;

    // An ack only counts while we are actually requesting and not being flushed.
    assign accept  = (state == IF_FETCH) && imem_ack_i && !redirect_i;
    assign to_ifid = accept && (!stall_i || !valid_o);
    assign to_skid = accept && stall_i && valid_o;
    assign unload  = (state == IF_HOLD) && !stall_i && !redirect_i;

    assign imem_addr_o = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req_o = 1'b0;
        case (state)
            IF_IDLE: begin
                state_next = IF_FETCH;
            end
            IF_FETCH: begin
                imem_req_o = 1'b1;
                if (to_skid) begin
                    state_next = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (!stall_i) begin
                    state_next = IF_FETCH;
                end
            end
            default: begin
                state_next = IF_IDLE;
            end
        endcase
        if (redirect_i) begin
            state_next = IF_FETCH;
        end
    end

    if_skid_buf #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (to_skid),
        .unload     (unload),
        .clear      (redirect_i),
        .load_instr (imem_rdata_i),
        .load_pc    (pc),
        .held_instr (skid_instr),
        .held_pc    (skid_pc),
        .full       (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_i) begin
            pc <= redirect_pc_i;
        end else if (accept) begin
            pc <= pc_inc(pc);
        end
    end

    // IF/ID pipeline register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_o    <= INSTR_W'(IF_NOP);
            pc_o    <= '0;
            valid_o <= 1'b0;
        end else if (redirect_i) begin
            ir_o    <= INSTR_W'(IF_NOP);
            valid_o <= 1'b0;
        end else if (to_ifid) begin
            ir_o    <= imem_rdata_i;
            pc_o    <= pc;
            valid_o <= 1'b1;
        end else if (unload && skid_full) begin
            ir_o    <= skid_instr;
            pc_o    <= skid_pc;
            valid_o <= 1'b1;
        end else if ((state == IF_FETCH) && !imem_ack_i && !stall_i) begin
            valid_o <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (accept) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if ((state != IF_IDLE) && !valid_o && !stall_i) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: FIFO scoreboard of accepted fetches against
// what decode consumes, plus per-scenario checks. Define IF_PERF_CNT_EN to cover counters.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    logic        force_en = 1'b0;
    logic [31:0] force_data = '0;

    int checks = 0;
    int failures = 0;
    int fetch_seen = 0;
    int bubble_seen = 0;
    sb_t sb_q[$];

    // Memory returns its address as data unless a specific word is forced.
    assign imem_rdata_i = force_en ? force_data : imem_addr_o;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    // One clock: at the negedge, retire what decode consumes and record what
    // the memory hands over; return #1 after the following posedge.
    task automatic clock_cycle();
        sb_t e;
        @(negedge clk);
        if (!rst) begin
            if (imem_req_o && imem_ack_i && !redirect_i) fetch_seen++;
            if (!valid_o && !stall_i) bubble_seen++;
            if (redirect_i) begin
                sb_q.delete();
            end else begin
                if (valid_o && !stall_i) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_extra ir_o=%h pc_o=%h required=no instruction", ir_o, pc_o);
                    end else begin
                        e = sb_q.pop_front();
                        if (ir_o !== e.ir || pc_o !== e.pc) begin
                            failures++;
                            $display("FAIL sb_order ir_o=%h pc_o=%h required ir=%h pc=%h",
                                     ir_o, pc_o, e.ir, e.pc);
                        end
                    end
                end
                if (imem_req_o && imem_ack_i) sb_q.push_back('{ir: imem_rdata_i, pc: imem_addr_o});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || ir_o !== 32'h0 || pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_values req=%b valid=%b ir=%h pc=%h addr=%h required 0/0/0/0/0",
                     imem_req_o, valid_o, ir_o, pc_o, imem_addr_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req req=%b required 0", imem_req_o);
        end
        clock_cycle();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL first_req req=%b addr=%h required 1/00000000", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_stream();
        imem_ack_i = 1'b1;
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clock_cycle();
            checks++;
            if (valid_o !== 1'b1 || ir_o !== 32'(i) || pc_o !== 32'(i)) begin
                failures++;
                $display("FAIL stream[%0d] valid=%b ir=%h pc=%h required 1/%h/%h", i, valid_o, ir_o, pc_o, i, i);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = ir_o;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clock_cycle();
            checks++;
            if (ir_o !== held || valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] ir=%h valid=%b req=%b required %h/1/0", i, ir_o, valid_o, imem_req_o, held);
            end
        end
        stall_i = 1'b0;
        clock_cycle();
        checks++;
        if (ir_o !== held + 32'd1 || valid_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== held + 32'd2) begin
            failures++;
            $display("FAIL skid_unload ir=%h valid=%b req=%b addr=%h required %h/1/1/%h",
                     ir_o, valid_o, imem_req_o, imem_addr_o, held + 32'd1, held + 32'd2);
        end
        clock_cycle();
        checks++;
        if (ir_o !== held + 32'd2) begin
            failures++;
            $display("FAIL after_skid ir=%h required %h", ir_o, held + 32'd2);
        end
    endtask

    task automatic test_redirect();
        imem_ack_i = 1'b1;
        stall_i = 1'b1;
        force_en = 1'b1;
        force_data = 32'h0000_DEAD;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        clock_cycle();
        redirect_i = 1'b0;
        force_en = 1'b0;
        stall_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ir_o !== 32'h0 || imem_addr_o !== 32'h40 || imem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL redirect_flush valid=%b ir=%h addr=%h req=%b required 0/00000000/00000040/1",
                     valid_o, ir_o, imem_addr_o, imem_req_o);
        end
        clock_cycle();
        checks++;
        if (ir_o === 32'h0000_DEAD || ir_o !== 32'h40 || pc_o !== 32'h40 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target ir=%h pc=%h valid=%b required 00000040/00000040/1", ir_o, pc_o, valid_o);
        end
    endtask

    task automatic test_bubble();
        logic [31:0] a;
        a = imem_addr_o;
        imem_ack_i = 1'b0;
        stall_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clock_cycle();
            checks++;
            if (valid_o !== 1'b0 || imem_addr_o !== a) begin
                failures++;
                $display("FAIL bubble[%0d] valid=%b addr=%h required 0/%h", i, valid_o, imem_addr_o, a);
            end
        end
        imem_ack_i = 1'b1;
        clock_cycle();
        checks++;
        if (valid_o !== 1'b1 || ir_o !== a || pc_o !== a) begin
            failures++;
            $display("FAIL bubble_resume valid=%b ir=%h pc=%h required 1/%h/%h", valid_o, ir_o, pc_o, a, a);
        end
    endtask

    task automatic test_reset_in_hold();
        imem_ack_i = 1'b1;
        stall_i = 1'b1;
        clock_cycle();
        checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL enter_hold req=%b valid=%b required 0/1", imem_req_o, valid_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || ir_o !== 32'h0 || pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL async_reset req=%b valid=%b ir=%h pc=%h addr=%h required 0/0/0/0/0",
                     imem_req_o, valid_o, ir_o, pc_o, imem_addr_o);
        end
        sb_q.delete();
        clock_cycle();
        rst = 1'b0;
        stall_i = 1'b0;
        clock_cycle();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL restart_req req=%b addr=%h required 1/00000000", imem_req_o, imem_addr_o);
        end
        clock_cycle();
        checks++;
        if (valid_o !== 1'b1 || ir_o !== 32'h0 || pc_o !== 32'h0) begin
            failures++;
            $display("FAIL restart_fetch valid=%b ir=%h pc=%h required 1/0/0", valid_o, ir_o, pc_o);
        end
    endtask

    task automatic test_wrap();
        imem_ack_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        clock_cycle();
        redirect_i = 1'b0;
        clock_cycle();
        checks++;
        if (ir_o !== 32'hFFFF_FFFF || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_edge ir=%h addr=%h required ffffffff/00000000", ir_o, imem_addr_o);
        end
        clock_cycle();
        checks++;
        if (ir_o !== 32'h0 || pc_o !== 32'h0 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL wrap_next ir=%h pc=%h valid=%b required 0/0/1", ir_o, pc_o, valid_o);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [31:0] f0, b0;
        int fs0, bs0;
        f0 = fetch_cnt_o;
        b0 = bubble_cnt_o;
        fs0 = fetch_seen;
        bs0 = bubble_seen;
        stall_i = 1'b0;
        imem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) clock_cycle();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        clock_cycle();
        redirect_i = 1'b0;
        imem_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) clock_cycle();
        imem_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) clock_cycle();
        checks++;
        if (fetch_cnt_o - f0 !== 32'd9 || fetch_seen - fs0 != 9) begin
            failures++;
            $display("FAIL perf_fetch delta=%0d required 9", fetch_cnt_o - f0);
        end
        checks++;
        if (bubble_cnt_o - b0 !== 32'(bubble_seen - bs0)) begin
            failures++;
            $display("FAIL perf_bubble delta=%0d required %0d", bubble_cnt_o - b0, bubble_seen - bs0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_bubble();
        test_reset_in_hold();
        test_wrap();
`ifdef IF_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage CPU, directly upstream of the decode stage.
- Generates the PC and drives a req/ack instruction-memory port.
- Holds the IF/ID pipeline register (ir_o, pc_o, valid_o) that decode consumes.
- Honours the decode stall (wait_ID) and the EX-stage branch redirect, including flush and a one-entry skid buffer.

Parameters:
- PC_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- PC_STEP, 1, PC increment per instruction (word-addressed memory).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  1  decode cannot accept (driven by wait_ID).
- redirect_i  in  1  taken branch/jump from EX; flush.
- redirect_pc_i  in  PC_W  target PC.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  PC_W  fetch address.
- imem_ack_i  in  1  imem_rdata_i valid for imem_addr_o of this same cycle.
- imem_rdata_i  in  INSTR_W  instruction word.
- ir_o  out  INSTR_W  IR to decode.
- pc_o  out  PC_W  PC of ir_o.
- valid_o  out  1  ir_o holds a real instruction.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - pc=RESET_PC, ir_o=NOP (32'h0; opcode 2'b00 has no effect in decode), pc_o=0, valid_o=0, imem_req_o=0.
  - Skid buffer empty; state=IDLE.
- State machine:
  - IDLE: req=0. Next cycle goes to FETCH. First request is issued the cycle after rst deasserts.
  - FETCH: req=1, addr=pc. A transfer completes in any cycle where ack=1. addr may change in a cycle without ack; an un-acked request is simply abandoned.
  - HOLD: skid full, req=0. Leaves when stall_i=0: skid moves into IF/ID, skid is cleared, state goes to FETCH.
- On ack in FETCH:
  - If stall_i=0 or valid_o=0: ir_o<=rdata, pc_o<=pc, valid_o<=1, pc<=pc+PC_STEP.
  - If stall_i=1 and valid_o=1: {rdata,pc} go into the skid, pc<=pc+PC_STEP, state goes to HOLD. ir_o, pc_o and valid_o are unchanged.
- No ack and stall_i=0: valid_o<=0 (bubble).
- No ack and stall_i=1: IF/ID holds.
- Redirect (highest priority, in any state, regardless of stall_i or ack):
  - pc<=redirect_pc_i, ir_o<=NOP, valid_o<=0, skid cleared, state goes to FETCH.
  - An ack arriving in the same cycle is discarded.
  - First fetch at the target is issued the next cycle.
- Latency: the instruction at address A appears on ir_o in the cycle after its ack, i.e. 1 cycle with a zero-wait memory. Throughput is 1 per cycle with ack held high.
- PC arithmetic wraps modulo 2^PC_W, with no trap.
- Reset asserted mid-transfer: immediate return to the reset values; any in-flight ack is ignored.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and bubble_cnt_o[31:0], both reset to 0 and wrapping.
  - fetch_cnt_o increments on each accepted ack (not on discarded ones).
  - bubble_cnt_o increments on each cycle where valid_o=0 and stall_i=0, after the IDLE cycle.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/def header:
  - NOP encoding.
  - IF state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2).
  - PC and instruction bus width constants, reused by decode.
- One sub-module, if_skid_buf: a single-entry {instr,pc} holding register with load/unload/clear and a full flag.

Test Plan:
- Reset, then ack held high with a memory returning the address as data → the first req has addr=0; ir_o shows 0,1,2,3 on consecutive cycles with valid_o=1 and pc_o matching.
- Ack on every cycle; stall_i high for 3 cycles while valid_o=1 → ir_o holds its value; one word is captured in the skid and req drops. After release, the skid word appears next with no instruction lost or duplicated.
- Redirect to 32'h40 in the same cycle as an ack with data 0xDEAD and stall_i=1 → next cycle valid_o=0, ir_o=0, addr=32'h40; 0xDEAD never appears on ir_o.
- Ack low for 2 cycles, no stall → valid_o=0 for those cycles; addr stays constant; the next ack loads the correct word.
- Assert rst while in HOLD → outputs return to reset values immediately (asynchronous); fetch restarts at RESET_PC.
- With IF_PERF_CNT_EN defined: 10 acks, 1 discarded by redirect, 2 bubbles → fetch_cnt_o=9, bubble_cnt_o equals the observed count of bubble cycles.
